kp_scan_fifo: RTL and testbench
===============================

// Module: kp_scan_fifo
// PURPOSE
//  Scans a 4x4 matrix keypad, debounces it and queues one 4-bit key code per press.
//  The queue is a small FIFO, so the CPU never misses keystrokes between polls.
//  Sits directly upstream of the GPIO decoder. That decoder shows key_valid/key_data at read address 0xbf80_0014.
//  It pulses rd_en for one clk cycle on each accepted read of that address.
// PARAMETERS
//  SCAN_DIV   50000  clk cycles each column is driven (min 4)
//  DEBOUNCE   4      consecutive identical full scans to accept a press or release (min 1)
//  FIFO_DEPTH 4      key queue entries (power of 2, >=2)
//  FIFO_AW    2      log2(FIFO_DEPTH)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active-low
//  row        in   4  keypad rows, active-low (pulled up), asynchronous to clk
//  col        out  4  keypad column drive, one-hot active-low
//  rd_en      in   1  pop FIFO head (1-cycle pulse)
//  clr_ovf    in   1  clear sticky overflow flag
//  key_data   out  4  FIFO head key code; 4'h0 when empty
//  key_valid  out  1  FIFO not empty
//  overflow   out  1  sticky: a press was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (rst=0, async): col=4'b1110, key_data=0, key_valid=0, overflow=0.
//   All counters, the FSM (S_IDLE) and the FIFO pointers clear.
//  Sync: row passes through a 2-flop synchronizer before use.
//  Scan:
//   - col cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110; each column holds SCAN_DIV cycles.
//   - Synced row is sampled on the last cycle of each column slot (cnt==SCAN_DIV-1).
//   - After column 3 is sampled, the 16-bit snapshot is complete: a "scan".
//  Decode per scan:
//   - No bit low -> NONE.
//   - Exactly one bit low at row r, col c -> code = 4*r + c.
//   - More than one bit low -> MULTI; treated as NONE for press detection, as not-released for release detection.
//  Debounce FSM, evaluated once per scan; cnt_db counts scans:
//   - S_IDLE: on a single key K, cand=K, cnt_db=1, go S_PRESS_DB; if DEBOUNCE==1, push K and go S_HELD directly.
//   - S_PRESS_DB:
//     - Same K: cnt_db++. When cnt_db reaches DEBOUNCE, push K and go S_HELD.
//     - Different single key J: cand=J, cnt_db=1.
//     - NONE or MULTI: go S_IDLE.
//   - S_HELD: stays here until a NONE scan, then cnt_db=1 and go S_REL_DB.
//     No auto-repeat; other keys pressed while held are ignored.
//   - S_REL_DB:
//     - NONE: cnt_db++. When cnt_db reaches DEBOUNCE, go S_IDLE.
//     - Any key or MULTI: go S_HELD.
//  FIFO:
//   - Push is a 1-cycle internal strobe on the scan-complete cycle. Entry is visible the next cycle.
//   - Pop and push in the same cycle are both honoured, including when full.
//   - Push when full with no pop: entry dropped, overflow<=1.
//   - Pop when empty: ignored, no pointer movement.
//   - clr_ovf clears overflow. If it coincides with a new drop, the set wins.
//   - key_data/key_valid are registered and reflect the head one cycle after any push or pop.
//   - Pointers wrap modulo FIFO_DEPTH. Count uses FIFO_AW+1 bits to distinguish full from empty.
//  Reset mid-operation: asserting rst at any time aborts the scan and empties the FIFO. Outputs return to reset values immediately.
// TESTING (SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4; 1 scan = 16 clk)
//  1 Reset/scan: release rst, no key -> col steps 1110,1101,1011,0111, 4 clk each. key_valid stays 0 for 10 scans.
//  2 Single press:
//    - Hold row1 low while col2 is driven, for 3 scans.
//    - -> exactly one push: key_valid=1, key_data=4'h6, no repeat.
//    - rd_en pulse -> key_valid=0, key_data=0 next cycle.
//  3 Bounce:
//    - Key 4'h3 present 1 scan, absent 1 scan, present 1 scan -> no push.
//    - Then present 2 consecutive scans -> push 4'h3.
//  4 Queue order/overflow:
//    - Press/release keys 1,2,3,4,5, each 3 scans, no reads -> after key 4 FIFO full; key 5 dropped, overflow=1.
//    - Pops return 1,2,3,4, then key_valid=0.
//    - clr_ovf -> overflow=0.
//  5 Full push+pop:
//    - FIFO full (1,2,3,4); rd_en on the same cycle key 5 is pushed -> overflow stays 0.
//    - Drain order 2,3,4,5.
//  6 Multi/reset:
//    - Keys 0 and 5 pressed together for 4 scans -> no push.
//    - Press key 9, assert rst in S_PRESS_DB -> all outputs at reset values. No push after release of rst until a fresh press.

Source files
------------

// File: rtl/kp_scan_fifo.sv
// 4x4 keypad scanner with per-scan debounce and a small key-code FIFO.
// One key code is queued per accepted press; the head is presented on key_data/key_valid.
module kp_scan_fifo #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    input  logic       rd_en,
    input  logic       clr_ovf,
    output logic [3:0] key_data,
    output logic       key_valid,
    output logic       overflow,
    output logic [1:0] dbg_state_o
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DB_N = DW'(DEBOUNCE);
    localparam logic [DW-1:0] DB_ONE = DW'(1);
    localparam logic [FIFO_AW:0] FULL_N = (FIFO_AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PRESS_DB = 2'd1;
    localparam logic [1:0] S_HELD     = 2'd2;
    localparam logic [1:0] S_REL_DB   = 2'd3;

    logic [3:0]    row_s1_q, row_s2_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    col_idx_q;
    logic [15:0]   snap_q, snap_d;
    logic          slot_end, scan_done;

    logic [4:0]    n_low;
    logic [3:0]    key_code;
    logic          single, none;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [DW-1:0] cnt_db_q, cnt_db_d, cnt_db_inc;
    logic          push;
    logic [3:0]    push_code;

    logic [3:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               full, empty, do_pop, do_push, drop;
    logic [3:0]         head_d;
    logic [3:0]         key_data_q;
    logic               key_valid_q, ovf_q;

    assign slot_end  = (cnt_q == CW'(SCAN_DIV - 1));
    assign scan_done = slot_end && (col_idx_q == 2'd3);
    assign col       = ~(4'b0001 << col_idx_q);

    // snap_d is the snapshot including the column being sampled this cycle; bit 4*r+c set = key pressed.
    always_comb begin
        snap_d = snap_q;
        if (slot_end) begin
            for (int r = 0; r < 4; r++) begin
                snap_d[{2'(r), col_idx_q}] = ~row_s2_q[r];
            end
        end
    end

    always_comb begin
        n_low    = '0;
        key_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap_d[i]) begin
                n_low    = n_low + 5'd1;
                key_code = 4'(i);
            end
        end
    end

    assign single     = (n_low == 5'd1);
    assign none       = (n_low == 5'd0);
    assign cnt_db_inc = cnt_db_q + DB_ONE;

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_db_d  = cnt_db_q;
        push      = 1'b0;
        push_code = cand_q;
        if (scan_done) begin
            case (state_q)
                S_IDLE: begin
                    if (single) begin
                        cand_d   = key_code;
                        cnt_db_d = DB_ONE;
                        if (DB_N == DB_ONE) begin
                            push      = 1'b1;
                            push_code = key_code;
                            state_d   = S_HELD;
                        end else begin
                            state_d = S_PRESS_DB;
                        end
                    end
                end
                S_PRESS_DB: begin
                    if (single && key_code == cand_q) begin
                        cnt_db_d = cnt_db_inc;
                        if (cnt_db_inc == DB_N) begin
                            push    = 1'b1;
                            state_d = S_HELD;
                        end
                    end else if (single) begin
                        cand_d   = key_code;
                        cnt_db_d = DB_ONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (none) begin
                        cnt_db_d = DB_ONE;
                        state_d  = (DB_N == DB_ONE) ? S_IDLE : S_REL_DB;
                    end
                end
                default: begin
                    if (none) begin
                        cnt_db_d = cnt_db_inc;
                        if (cnt_db_inc == DB_N) state_d = S_IDLE;
                    end else begin
                        state_d = S_HELD;
                    end
                end
            endcase
        end
    end

    // A pop frees the slot a same-cycle push needs, so push+pop is honoured even when full.
    assign full    = (count_q == FULL_N);
    assign empty   = (count_q == '0);
    assign do_pop  = rd_en && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    always_comb begin
        rd_ptr_d = do_pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
        head_d = (do_push && rd_ptr_d == wr_ptr_q) ? push_code : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1_q  <= 4'hF;
            row_s2_q  <= 4'hF;
            cnt_q     <= '0;
            col_idx_q <= 2'd0;
            snap_q    <= '0;
            state_q   <= S_IDLE;
            cand_q    <= '0;
            cnt_db_q  <= '0;
        end else begin
            row_s1_q <= row;
            row_s2_q <= row_s1_q;
            snap_q   <= snap_d;
            if (slot_end) begin
                cnt_q     <= '0;
                col_idx_q <= col_idx_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_db_q <= cnt_db_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            key_data_q  <= '0;
            key_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_code;
                wr_ptr_q        <= wr_ptr_q + FIFO_AW'(1);
            end
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            key_valid_q <= (count_d != '0);
            key_data_q  <= (count_d != '0) ? head_d : 4'h0;
            if (drop)         ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
        end
    end

    assign key_data    = key_data_q;
    assign key_valid   = key_valid_q;
    assign overflow    = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_kp_scan_fifo.sv
// Bench for kp_scan_fifo: directed keypad scenarios plus a randomized run,
// all checked against a scan-level keypad/debounce/queue reference model.
module tb_kp_scan_fifo;

    localparam int SD = 4;
    localparam int DB = 2;
    localparam int FD = 4;
    localparam int SCAN_CYC = 4 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [3:0] key_data;
    logic       key_valid;
    logic       overflow;
    logic [1:0] dbg_state;

    logic [15:0] keys_down = '0;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];
    bit m_ovf, m_held;
    int m_run, m_last;
    int phase;

    kp_scan_fifo #(.SCAN_DIV(SD), .DEBOUNCE(DB), .FIFO_DEPTH(FD), .FIFO_AW(2)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .rd_en(rd_en), .clr_ovf(clr_ovf),
        .key_data(key_data), .key_valid(key_valid), .overflow(overflow), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col[c] && keys_down[4*r+c]) row[r] = 1'b0;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        exp_q.delete();
        m_ovf = 0; m_held = 0; m_run = 0; m_last = -3; phase = 0;
    endtask

    // One complete scan seen by the keypad user: accept a press after DB identical
    // single-key scans, a release after DB empty scans.
    task automatic model_scan();
        int n, code, dec;
        n = 0; code = 0;
        for (int i = 0; i < 16; i++) if (keys_down[i]) begin n++; code = i; end
        dec = (n == 0) ? -1 : (n > 1) ? -2 : code;
        if (dec == m_last) m_run++;
        else begin m_run = 1; m_last = dec; end
        if (!m_held && dec >= 0 && m_run == DB) begin
            m_held = 1;
            if (exp_q.size() < FD) exp_q.push_back(4'(dec));
            else m_ovf = 1;
        end else if (m_held && dec == -1 && m_run == DB) begin
            m_held = 0;
        end
    endtask

    task automatic step(input bit rd, input bit clr);
        rd_en = rd; clr_ovf = clr;
        @(posedge clk); #1;
        rd_en = 1'b0; clr_ovf = 1'b0;
        if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
        if (clr) m_ovf = 0;
        phase++;
        if (phase == SCAN_CYC) begin
            model_scan();
            phase = 0;
        end
    endtask

    task automatic run_scans(input int n, input bit pop_last);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < SCAN_CYC; i++)
                step(pop_last && (k == n - 1) && (i == SCAN_CYC - 1), 1'b0);
    endtask

    task automatic align();
        while (phase != 0) step(1'b0, 1'b0);
    endtask

    task automatic set_key(input int code);
        logic [15:0] one;
        one = 16'h0001;
        keys_down = one << code;
    endtask

    task automatic press_release(input int code, input int np, input int nr);
        set_key(code);
        run_scans(np, 1'b0);
        keys_down = '0;
        run_scans(nr, 1'b0);
    endtask

    task automatic test_reset();
        logic [3:0] one, exp_col;
        one = 4'b0001;
        rst = 1'b0; keys_down = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col got=%b exp=1110", col); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        checks++; if (key_data !== 4'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", key_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < SCAN_CYC; i++) begin
            step(1'b0, 1'b0);
            exp_col = ~(one << ((phase / SD) % 4));
            checks++;
            if (col !== exp_col) begin errors++; $display("FAIL scan_col cyc=%0d got=%b exp=%b", i + 1, col, exp_col); end
        end
        for (int s = 0; s < 9; s++) begin
            run_scans(1, 1'b0);
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL idle_valid scan=%0d got=%b exp=0", s, key_valid); end
        end
    endtask

    task automatic test_single_press();
        keys_down = '0;
        keys_down[6] = 1'b1;
        for (int s = 0; s < 3; s++) begin
            run_scans(1, 1'b0);
            checks++;
            if (key_valid !== (s >= 1)) begin errors++; $display("FAIL press6_valid scan=%0d got=%b exp=%b", s, key_valid, s >= 1); end
        end
        checks++; if (key_data !== 4'h6) begin errors++; $display("FAIL press6_data got=%h exp=6", key_data); end
        keys_down = '0;
        run_scans(3, 1'b0);
        step(1'b1, 1'b0);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL pop6_valid got=%b exp=0 (no repeat)", key_valid); end
        checks++; if (key_data !== 4'h0) begin errors++; $display("FAIL pop6_data got=%h exp=0", key_data); end
        align();
    endtask

    task automatic test_bounce();
        int pat[4] = '{1, 0, 1, 0};
        foreach (pat[i]) begin
            if (pat[i] != 0) set_key(3); else keys_down = '0;
            run_scans(1, 1'b0);
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL bounce_nopush scan=%0d got=%b exp=0", i, key_valid); end
        end
        set_key(3);
        run_scans(2, 1'b0);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL bounce_push_valid got=%b exp=1", key_valid); end
        checks++; if (key_data !== 4'h3) begin errors++; $display("FAIL bounce_push_data got=%h exp=3", key_data); end
        keys_down = '0;
        run_scans(3, 1'b0);
        step(1'b1, 1'b0);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL bounce_drain got=%b exp=0", key_valid); end
        align();
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 5; k++) begin
            press_release(k, 3, 3);
            checks++;
            if (overflow !== (k == 5)) begin errors++; $display("FAIL ovf_after_key%0d got=%b exp=%b", k, overflow, k == 5); end
        end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (key_valid !== 1'b1 || key_data !== 4'(k)) begin
                errors++; $display("FAIL order_pop%0d got=%b/%h exp=1/%h", k, key_valid, key_data, 4'(k));
            end
            step(1'b1, 1'b0);
        end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL order_empty got=%b exp=0", key_valid); end
        step(1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got=%b exp=0", overflow); end
        align();
    endtask

    task automatic test_full_push_pop();
        for (int k = 1; k <= 4; k++) press_release(k, 3, 3);
        set_key(5);
        run_scans(1, 1'b0);
        run_scans(1, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_ovf got=%b exp=0", overflow); end
        run_scans(1, 1'b0);
        keys_down = '0;
        run_scans(3, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            checks++;
            if (key_valid !== 1'b1 || key_data !== 4'(k)) begin
                errors++; $display("FAIL fullpp_drain%0d got=%b/%h exp=1/%h", k, key_valid, key_data, 4'(k));
            end
            step(1'b1, 1'b0);
        end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL fullpp_empty got=%b exp=0", key_valid); end
        align();
    endtask

    task automatic test_multi_reset();
        press_release(7, 3, 3);
        keys_down = '0;
        keys_down[0] = 1'b1; keys_down[5] = 1'b1;
        run_scans(4, 1'b0);
        keys_down = '0;
        run_scans(3, 1'b0);
        checks++; if (key_data !== 4'h7) begin errors++; $display("FAIL multi_head got=%h exp=7", key_data); end
        step(1'b1, 1'b0);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL multi_nopush got=%b exp=0", key_valid); end
        align();
        press_release(7, 3, 3);
        set_key(9);
        run_scans(1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checks++;
        if (col !== 4'b1110 || key_valid !== 1'b0 || key_data !== 4'h0 || overflow !== 1'b0) begin
            errors++; $display("FAIL midreset col=%b valid=%b data=%h ovf=%b exp=1110/0/0/0", col, key_valid, key_data, overflow);
        end
        keys_down = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        run_scans(3, 1'b0);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL postreset_nopush got=%b exp=0", key_valid); end
        press_release(9, 3, 3);
        checks++;
        if (key_valid !== 1'b1 || key_data !== 4'h9) begin
            errors++; $display("FAIL fresh_press got=%b/%h exp=1/9", key_valid, key_data);
        end
        step(1'b1, 1'b0);
        align();
    endtask

    task automatic test_random();
        int kind, a, b, hold;
        logic [3:0] exp_d;
        for (int seg = 0; seg < 40; seg++) begin
            kind = $urandom_range(0, 9);
            keys_down = '0;
            if (kind >= 4 && kind <= 8) begin
                set_key($urandom_range(0, 15));
            end else if (kind == 9) begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                keys_down[a] = 1'b1; keys_down[b] = 1'b1;
            end
            hold = $urandom_range(1, 3);
            for (int c = 0; c < hold * SCAN_CYC; c++) begin
                step($urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
                exp_d = (exp_q.size() != 0) ? exp_q[0] : 4'h0;
                checks++;
                if (key_valid !== (exp_q.size() != 0) || key_data !== exp_d || overflow !== m_ovf) begin
                    errors++;
                    $display("FAIL rand seg=%0d cyc=%0d got=%b/%h/%b exp=%b/%h/%b", seg, c,
                             key_valid, key_data, overflow, exp_q.size() != 0, exp_d, m_ovf);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_bounce();
        test_overflow();
        test_full_push_pop();
        test_multi_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
